// File: rtl/exc_pkg.sv
// exc_pkg: shared ESR codes and sequencer state encoding for exc_ctrl
package exc_pkg;
  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_IRQ    = 4'b0001;
  localparam logic [3:0] ESR_BADOP  = 4'b0010;
  localparam logic [3:0] ESR_DOUBLE = 4'b1111;
  typedef enum logic [2:0] {RUN, FLUSH, VECTOR, HANDLER, RETURN, HALT} state_t;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchronizer with a one-cycle rising-edge pulse
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);
  logic [2:0] sh;
  always_ff @(posedge clk or posedge reset)
    if (reset) sh <= '0;
    else sh <= {sh[1:0], async_in};
  assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: LEGv8 exception sequencer driving flush, vector and ERET redirection
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int              PC_W         = 64,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] EXC_VECTOR   = 'h0000_0000_0000_00D8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ExtIRQ,
  input  logic            instr_valid,
  input  logic            NotAnInstr,
  input  logic            ERet,
  input  logic [PC_W-1:0] pc_d,
  output logic            exc_flush,
  output logic            pc_sel_exc,
  output logic            pc_sel_eret,
  output logic [PC_W-1:0] exc_vector_o,
  output logic [PC_W-1:0] elr_o,
  output logic [3:0]      esr_o,
  output logic            in_handler,
  output logic            irq_ack,
  output logic            halt
);
  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n, esr_n;
  logic [PC_W-1:0] elr_n;
  logic            irq_edge, irq_pend;
  irq_sync u_sync (.clk, .reset, .async_in(ExtIRQ), .rise(irq_edge));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      elr_o    <= '0;
      esr_o    <= ESR_NONE;
      irq_pend <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      elr_o    <= elr_n;
      esr_o    <= esr_n;
      irq_pend <= irq_edge | (irq_pend & ~irq_ack);
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    elr_n   = elr_o;
    esr_n   = esr_o;
    irq_ack = 1'b0;
    case (state)
      RUN: if (instr_valid && (irq_pend || NotAnInstr)) begin
        irq_ack = irq_pend;
        state_n = FLUSH;
        cnt_n   = 4'(FLUSH_CYCLES - 1);
        elr_n   = pc_d;
        esr_n   = irq_pend ? ESR_IRQ : ESR_BADOP;
      end
      FLUSH: begin
        cnt_n   = (cnt == '0) ? cnt : cnt - 4'd1;
        state_n = (cnt == '0) ? VECTOR : FLUSH;
      end
      VECTOR: state_n = HANDLER;
      HANDLER: if (instr_valid && NotAnInstr) begin
        state_n = HALT;
        esr_n   = ESR_DOUBLE;
      end else if (instr_valid && ERet) state_n = RETURN;
      RETURN: begin
        state_n = RUN;
        esr_n   = ESR_NONE;
      end
      default: state_n = HALT;
    endcase
  end
  assign exc_flush    = state inside {FLUSH, VECTOR, RETURN, HALT};
  assign pc_sel_exc   = state == VECTOR;
  assign pc_sel_eret  = state == RETURN;
  assign in_handler   = state == HANDLER;
  assign halt         = state == HALT;
  assign exc_vector_o = EXC_VECTOR;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and randomized checks of exc_ctrl against a phase-level model
module tb_exc_ctrl;
  localparam int F = 2;
  localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;
  localparam int M_RUN = 0, M_EXC = 1, M_HND = 2, M_RET = 3, M_HALT = 4;
  logic clk = 0, reset = 0, ExtIRQ = 0, instr_valid = 0, NotAnInstr = 0, ERet = 0;
  logic [63:0] pc_d = '0;
  logic exc_flush, pc_sel_exc, pc_sel_eret, in_handler, irq_ack, halt;
  logic [63:0] exc_vector_o, elr_o;
  logic [3:0] esr_o;
  int tests = 0, fails = 0;
  int m_mode = M_RUN, m_t = 0;
  logic m_pend = 0, h1 = 0, h2 = 0, h3 = 0;
  logic [63:0] m_elr = '0;
  logic [3:0] m_esr = '0;
  logic e_flush, e_sel_exc, e_sel_eret, e_inh, e_ack, e_halt;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .instr_valid(instr_valid),
    .NotAnInstr(NotAnInstr), .ERet(ERet), .pc_d(pc_d), .exc_flush(exc_flush),
    .pc_sel_exc(pc_sel_exc), .pc_sel_eret(pc_sel_eret), .exc_vector_o(exc_vector_o),
    .elr_o(elr_o), .esr_o(esr_o), .in_handler(in_handler), .irq_ack(irq_ack), .halt(halt)
  );

  always #5 clk = ~clk;

  always_comb begin
    e_ack      = (m_mode == M_RUN) && instr_valid && m_pend;
    e_flush    = (m_mode == M_EXC) || (m_mode == M_RET) || (m_mode == M_HALT);
    e_sel_exc  = (m_mode == M_EXC) && (m_t == F);
    e_sel_eret = m_mode == M_RET;
    e_inh      = m_mode == M_HND;
    e_halt     = m_mode == M_HALT;
  end

  task automatic model_reset();
    m_mode = M_RUN; m_t = 0; m_pend = 0; m_elr = '0; m_esr = '0;
    h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic cycle();
    logic ev, ack, acc;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      ev  = h2 & ~h3;
      ack = (m_mode == M_RUN) && instr_valid && m_pend;
      acc = instr_valid && (m_pend || NotAnInstr);
      case (m_mode)
        M_RUN: if (acc) begin
          m_elr = pc_d; m_esr = m_pend ? 4'h1 : 4'h2; m_mode = M_EXC; m_t = 0;
        end
        M_EXC: if (m_t == F) m_mode = M_HND; else m_t++;
        M_HND: if (instr_valid && NotAnInstr) begin
          m_esr = 4'hF; m_mode = M_HALT;
        end else if (instr_valid && ERet) m_mode = M_RET;
        M_RET: begin m_esr = 4'h0; m_mode = M_RUN; end
        default: ;
      endcase
      m_pend = ev | (m_pend & ~ack);
      h3 = h2; h2 = h1; h1 = ExtIRQ;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic nai, input logic er, input logic [63:0] pc);
    instr_valid = iv; NotAnInstr = nai; ERet = er; pc_d = pc;
    #1;
  endtask

  task automatic do_reset();
    reset = 1; model_reset(); drive(0, 0, 0, '0);
    cycle();
    reset = 0; #1;
  endtask

  task automatic go_handler(input logic [63:0] pc);
    drive(1, 1, 0, pc); cycle();
    drive(0, 0, 0, '0);
    repeat (F + 1) cycle();
  endtask

  task automatic go_return();
    drive(1, 0, 1, '0); cycle();
    drive(0, 0, 0, '0); cycle();
  endtask

  task automatic test_reset();
    reset = 1; model_reset(); drive(0, 0, 0, '0);
    tests++;
    if ({exc_flush, pc_sel_exc, pc_sel_eret, in_handler, irq_ack, halt} !== 6'b0 || elr_o !== '0 || esr_o !== 4'h0)
      begin fails++; $display("FAIL reset_state outs=%b elr=%h esr=%b exp all zero", {exc_flush, pc_sel_exc, pc_sel_eret, in_handler, irq_ack, halt}, elr_o, esr_o); end
    tests++;
    if (exc_vector_o !== VEC) begin fails++; $display("FAIL vector got=%h exp=%h", exc_vector_o, VEC); end
    cycle(); reset = 0; #1;
    drive(1, 1, 0, 64'h40); cycle(); drive(0, 0, 0, '0);
    tests++;
    if (exc_flush !== 1'b1) begin fails++; $display("FAIL reset_pre_flush got=%b exp=1", exc_flush); end
    reset = 1; model_reset(); #1;
    tests++;
    if ({exc_flush, pc_sel_exc, in_handler} !== 3'b0 || elr_o !== '0 || esr_o !== 4'h0)
      begin fails++; $display("FAIL reset_mid_flush outs=%b elr=%h esr=%b exp zero", {exc_flush, pc_sel_exc, in_handler}, elr_o, esr_o); end
    cycle(); reset = 0; #1;
    repeat (3) cycle();
    tests++;
    if ({exc_flush, pc_sel_exc, in_handler} !== 3'b0) begin fails++; $display("FAIL reset_run outs=%b exp 000", {exc_flush, pc_sel_exc, in_handler}); end
  endtask

  task automatic test_badop();
    drive(1, 1, 0, 64'h40);
    tests++;
    if (irq_ack !== 1'b0) begin fails++; $display("FAIL badop_ack got=%b exp=0", irq_ack); end
    cycle(); drive(0, 0, 0, '0);
    for (int c = 1; c <= F + 2; c++) begin
      tests++;
      if ({exc_flush, pc_sel_exc, in_handler} !== {c <= F + 1, c == F + 1, c > F + 1})
        begin fails++; $display("FAIL badop_seq c=%0d got=%b exp=%b", c, {exc_flush, pc_sel_exc, in_handler}, {c <= F + 1, c == F + 1, c > F + 1}); end
      if (c < F + 2) cycle();
    end
    tests++;
    if (elr_o !== 64'h40 || esr_o !== 4'b0010) begin fails++; $display("FAIL badop_regs elr=%h esr=%b exp 40/0010", elr_o, esr_o); end
    drive(1, 0, 1, 64'h999);
    tests++;
    if (pc_sel_eret !== 1'b0) begin fails++; $display("FAIL eret_early got=%b exp=0", pc_sel_eret); end
    cycle(); drive(0, 0, 0, '0);
    tests++;
    if ({pc_sel_eret, exc_flush, pc_sel_exc} !== 3'b110 || elr_o !== 64'h40)
      begin fails++; $display("FAIL eret_cycle got=%b elr=%h exp 110/40", {pc_sel_eret, exc_flush, pc_sel_exc}, elr_o); end
    cycle();
    tests++;
    if ({pc_sel_eret, exc_flush, in_handler} !== 3'b0 || esr_o !== 4'h0 || elr_o !== 64'h40)
      begin fails++; $display("FAIL eret_done got=%b esr=%b elr=%h exp 000/0000/40", {pc_sel_eret, exc_flush, in_handler}, esr_o, elr_o); end
  endtask

  task automatic test_irq_level();
    int k_ack = 0, acks = 0;
    drive(1, 0, 0, 64'h100); ExtIRQ = 1;
    for (int k = 1; k <= 10 && k_ack == 0; k++) begin
      cycle(); drive(1, 0, 0, 64'h100);
      if (irq_ack === 1'b1) k_ack = k;
    end
    tests++;
    if (k_ack !== 3) begin fails++; $display("FAIL irq_latency got=%0d exp=3", k_ack); end
    cycle(); drive(0, 0, 0, '0);
    repeat (F + 1) cycle();
    tests++;
    if (in_handler !== 1'b1 || elr_o !== 64'h100 || esr_o !== 4'b0001)
      begin fails++; $display("FAIL irq_regs inh=%b elr=%h esr=%b exp 1/100/0001", in_handler, elr_o, esr_o); end
    go_return();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 64'h200);
      if (irq_ack === 1'b1) acks++;
      cycle();
    end
    tests++;
    if (acks !== 0 || exc_flush !== 1'b0) begin fails++; $display("FAIL irq_held_once acks=%0d flush=%b exp 0/0", acks, exc_flush); end
    ExtIRQ = 0; drive(0, 0, 0, '0);
    repeat (4) cycle();
  endtask

  task automatic test_irq_badop();
    int bad = 0;
    ExtIRQ = 1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 64'h300);
      if (irq_ack !== 1'b0 || exc_flush !== 1'b0) bad++;
      cycle();
    end
    ExtIRQ = 0;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bubble_accept cycles=%0d exp=0", bad); end
    drive(1, 1, 0, 64'h300);
    tests++;
    if (irq_ack !== 1'b1) begin fails++; $display("FAIL both_ack got=%b exp=1", irq_ack); end
    cycle(); drive(0, 0, 0, '0);
    repeat (F + 1) cycle();
    tests++;
    if (esr_o !== 4'b0001 || elr_o !== 64'h300) begin fails++; $display("FAIL both_esr esr=%b elr=%h exp 0001/300", esr_o, elr_o); end
    go_return();
  endtask

  task automatic test_nested();
    int bad = 0;
    go_handler(64'h500);
    ExtIRQ = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) ExtIRQ = 0;
      drive(1, 0, 0, 64'h510);
      if (irq_ack !== 1'b0 || in_handler !== 1'b1) bad++;
      cycle();
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL nested_masked cycles=%0d exp=0", bad); end
    drive(1, 0, 1, '0); cycle();
    drive(1, 0, 0, 64'h600);
    tests++;
    if (irq_ack !== 1'b0 || pc_sel_eret !== 1'b1) begin fails++; $display("FAIL nested_ret ack=%b eret=%b exp 0/1", irq_ack, pc_sel_eret); end
    cycle(); drive(1, 0, 0, 64'h600);
    tests++;
    if (irq_ack !== 1'b1) begin fails++; $display("FAIL nested_take got=%b exp=1", irq_ack); end
    cycle(); drive(0, 0, 0, '0);
    repeat (F + 1) cycle();
    tests++;
    if (elr_o !== 64'h600 || esr_o !== 4'b0001 || in_handler !== 1'b1)
      begin fails++; $display("FAIL nested_regs elr=%h esr=%b inh=%b exp 600/0001/1", elr_o, esr_o, in_handler); end
  endtask

  task automatic test_double();
    int bad = 0;
    drive(1, 1, 1, 64'h700); cycle(); drive(0, 0, 0, '0);
    tests++;
    if ({halt, exc_flush, in_handler} !== 3'b110 || esr_o !== 4'b1111)
      begin fails++; $display("FAIL double got=%b esr=%b exp 110/1111", {halt, exc_flush, in_handler}, esr_o); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 64'h710);
      if ({halt, exc_flush, pc_sel_eret} !== 3'b110 || esr_o !== 4'b1111) bad++;
      cycle();
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL halt_sticky cycles=%0d exp=0", bad); end
    do_reset();
    tests++;
    if ({halt, exc_flush} !== 2'b00) begin fails++; $display("FAIL halt_reset got=%b exp=00", {halt, exc_flush}); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0 || (m_mode == M_HALT && $urandom_range(19) == 0)) begin
        reset = 1; model_reset();
      end
      if ($urandom_range(11) == 0) ExtIRQ = ~ExtIRQ;
      drive($urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(5) == 0, {$urandom, $urandom});
      tests++;
      if ({exc_flush, pc_sel_exc, pc_sel_eret, in_handler, irq_ack, halt} !== {e_flush, e_sel_exc, e_sel_eret, e_inh, e_ack, e_halt})
        begin fails++; $display("FAIL rand_ctl n=%0d got=%b exp=%b", n, {exc_flush, pc_sel_exc, pc_sel_eret, in_handler, irq_ack, halt}, {e_flush, e_sel_exc, e_sel_eret, e_inh, e_ack, e_halt}); end
      tests++;
      if (elr_o !== m_elr || esr_o !== m_esr) begin fails++; $display("FAIL rand_regs n=%0d elr=%h esr=%b exp %h/%b", n, elr_o, esr_o, m_elr, m_esr); end
      tests++;
      if (pc_sel_exc === 1'b1 && pc_sel_eret === 1'b1) begin fails++; $display("FAIL rand_sel_excl n=%0d got=11 exp not both", n); end
      cycle();
      if (reset) begin reset = 0; #1; end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_badop();
    test_irq_level();
    test_irq_badop();
    test_nested();
    test_double();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
